store_buffer: RTL and testbench

- Posted-write buffer between the single-cycle MIPS core's store port (memwrite/dataadr/writedata) and the data memory.
- Captures each store in one cycle into a FIFO and drains it to memory over a valid/ready handshake.
- Stalls the core only when the FIFO is full.
- Optionally forwards buffered store data to loads (read-after-write).

---
 rtl/store_buffer.sv | 167 ++++++++++++++++
 tb/tb_store_buffer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between a single-cycle core's store port
// and data memory. Each store is captured in one cycle into a DEPTH-entry FIFO
// and drained to memory over a valid/ready handshake; the core is stalled only
// when the FIFO is full.
//
// Optional feature macro: STORE_BUF_FWD_EN
//   defined   - loads are compared against every buffered store and the
//               youngest match is forwarded on rd_hit/rd_data (no load stall).
//   undefined - rd_hit/rd_data tied 0; a load stalls until the buffer drains.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   memwrite, dataadr,  core store strobe, byte address (store and load),
//   writedata, memread  store data, load strobe
//   stall               core must hold its current instruction
//   mem_valid/addr/wdata head entry presented to memory (0 while empty)
//   mem_ready           memory accepts the head entry this cycle
//   rd_hit, rd_data     load forwarding result
//   count, empty        occupancy

// One FIFO slot: word address, data and a valid flag.
module store_buffer_entry #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          clr,
  input  logic [AW-3:0] wadr,
  input  logic [DW-1:0] wdat,
  output logic          vld,
  output logic [AW-3:0] adr,
  output logic [DW-1:0] dat
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= 1'b0;
      adr <= '0;
      dat <= '0;
    end else if (we) begin
      vld <= 1'b1;
      adr <= wadr;
      dat <= wdat;
    end else if (clr) begin
      vld <= 1'b0;
    end
  end
endmodule

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwrite,
  input  logic [AW-1:0]          dataadr,
  input  logic [DW-1:0]          writedata,
  input  logic                   memread,
  output logic                   stall,
  output logic                   mem_valid,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ready,
  output logic                   rd_hit,
  output logic [DW-1:0]          rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          full, push, pop;

  logic [DEPTH-1:0]           evld;
  logic [DEPTH-1:0][AW-3:0]   eadr;
  logic [DEPTH-1:0][DW-1:0]   edat;

  // All stores are full-word; the byte offset is dropped on entry.
  logic unused_lsb;
  assign unused_lsb = ^dataadr[1:0];

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;

  // full is registered occupancy, so a same-cycle pop never lifts the stall.
  assign push = memwrite & ~full;
  assign pop  = ~empty & mem_ready;

  // evld[rptr] is set exactly when the FIFO is non-empty, so the head mux
  // naturally presents 0 while empty.
  assign mem_valid = ~empty;
  assign mem_addr  = evld[rptr] ? {eadr[rptr], 2'b00} : '0;
  assign mem_wdata = evld[rptr] ? edat[rptr] : '0;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      store_buffer_entry #(.AW(AW), .DW(DW)) u_ent (
        .clk  (clk),
        .reset(reset),
        .we   (push && (wptr == PW'(i))),
        .clr  (pop && (rptr == PW'(i))),
        .wadr (dataadr[AW-1:2]),
        .wdat (writedata),
        .vld  (evld[i]),
        .adr  (eadr[i]),
        .dat  (edat[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [DEPTH-1:0] ehit;

  generate
    for (i = 0; i < DEPTH; i++) begin : g_cmp
      assign ehit[i] = evld[i] & (eadr[i] == dataadr[AW-1:2]);
    end
  endgenerate

  // Walk oldest to youngest from the head; the last match wins, giving the
  // youngest store. The entry popping this cycle is still valid here.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (memread) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ehit[rptr + PW'(k)]) begin
          rd_hit  = 1'b1;
          rd_data = edat[rptr + PW'(k)];
        end
      end
    end
  end

  assign stall = memwrite & full;
`else
  assign rd_hit  = 1'b0;
  assign rd_data = '0;
  // Without forwarding, loads wait until every posted store has landed.
  assign stall   = (memwrite & full) | (memread & ~empty);
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, reset = 1'b0;
  logic          memwrite = 1'b0, memread = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] dataadr = '0;
  logic [DW-1:0] writedata = '0;
  logic          stall, mem_valid, rd_hit, empty;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rd_data;
  logic [CW-1:0] count;

  int vectors = 0, miscompares = 0;
  bit run = 1'b0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];        // buffered stores, oldest first
  logic [AW-1:0] drained[$];  // addresses accepted by memory, in order

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .memread(memread), .stall(stall),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .rd_hit(rd_hit), .rd_data(rd_data),
    .count(count), .empty(empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of posted stores.
  always @(negedge reset) q.delete();

  always @(posedge clk) begin
    bit do_pop, do_push;
    if (!reset) q.delete();
    else begin
      do_pop  = (q.size() != 0) && mem_ready;
      do_push = memwrite && (q.size() != DEPTH);
      if (do_pop) begin
        drained.push_back(q[0].a);
        void'(q.pop_front());
      end
      if (do_push) q.push_back('{{dataadr[AW-1:2], 2'b00}, writedata});
    end
  end

  // Compare every cycle, mid-way between active edges.
  always @(negedge clk) begin
    int            n;
    logic          es, eh;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, erd;
    if (run) begin
      n = q.size();
      if (n != 0) begin ea = q[0].a; ed = q[0].d; end
      else begin ea = '0; ed = '0; end
      es  = memwrite && (n == DEPTH);
      eh  = 1'b0;
      erd = '0;
`ifdef STORE_BUF_FWD_EN
      if (memread)
        for (int k = n - 1; k >= 0; k--)
          if (q[k].a == {dataadr[AW-1:2], 2'b00}) begin
            eh = 1'b1; erd = q[k].d; break;
          end
`else
      if (memread && n != 0) es = 1'b1;
`endif
      chk("count", count, n);
      chk("empty", empty, n == 0);
      chk("mem_valid", mem_valid, n != 0);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
      chk("stall", stall, es);
      chk("rd_hit", rd_hit, eh);
      chk("rd_data", rd_data, erd);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic st(input logic [AW-1:0] a, input logic [DW-1:0] d);
    memwrite = 1'b1; memread = 1'b0; dataadr = a; writedata = d;
  endtask

  task automatic idle();
    memwrite = 1'b0; memread = 1'b0;
  endtask

  initial begin
    int prob;
    // 1. reset state
    #22 reset = 1'b1;
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_valid", mem_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdhit", rd_hit, 0);
    run = 1'b1;

    // 2. two stores held, then drained in order
    mem_ready = 1'b0;
    st(80, 7); tick();
    st(84, 7); tick();
    idle(); #1;
    chk("t2_count", count, 2);
    repeat (3) begin
      chk("t2_valid", mem_valid, 1);
      chk("t2_addr", mem_addr, 80);
      chk("t2_data", mem_wdata, 7);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("t2_head0", mem_addr, 80);
    tick();
    chk("t2_head1", mem_addr, 84);
    tick();
    chk("t2_empty", empty, 1);
    mem_ready = 1'b0;

    // 4. unaligned store address is word-aligned
    st(86, 32'hDEADBEEF); tick();
    idle(); #1;
    chk("t4_addr", mem_addr, 84);
    chk("t4_data", mem_wdata, 32'hDEADBEEF);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    chk("t4_empty", empty, 1);

    // 3. full stall, pop does not lift it in the same cycle
    drained.delete();
    for (int i = 0; i < DEPTH; i++) begin
      st(4 * i, 32'h10 + i); #1;
      chk("t3_nostall", stall, 0);
      tick();
    end
    st(16, 32'h14); #1;
    chk("t3_stall", stall, 1);
    chk("t3_full", count, 4);
    tick();
    chk("t3_held", count, 4);
    mem_ready = 1'b1; #1;
    chk("t3_stall_pop", stall, 1);
    tick();
    mem_ready = 1'b0; #1;
    chk("t3_unstall", stall, 0);
    tick();
    idle(); #1;
    chk("t3_refill", count, 4);
    chk("t3_head", mem_addr, 4);
    mem_ready = 1'b1; repeat (DEPTH) tick(); mem_ready = 1'b0;
    chk("t3_empty", empty, 1);
    for (int i = 0; i < 5; i++) chk("t3_order", drained[i], 4 * i);

    // 5. sustained push+pop at count 2, pointers wrap
    drained.delete();
    st(32'h100, 1); tick();
    st(32'h104, 2); tick();
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      st(32'h108 + 4 * i, 3 + i); #1;
      chk("t5_count", count, 2);
      tick();
    end
    idle(); repeat (2) tick(); mem_ready = 1'b0; #1;
    chk("t5_empty", empty, 1);
    chk("t5_n", drained.size(), 8);
    for (int i = 0; i < 8; i++) chk("t5_order", drained[i], 32'h100 + 4 * i);

    // 6. load behaviour
`ifdef STORE_BUF_FWD_EN
    st(84, 7); tick();
    st(84, 9); tick();
    memwrite = 1'b0; memread = 1'b1; dataadr = 84; #1;
    chk("t6_hit", rd_hit, 1);
    chk("t6_data", rd_data, 9);
    chk("t6_nostall", stall, 0);
    dataadr = 88; #1;
    chk("t6_miss", rd_hit, 0);
    chk("t6_missdata", rd_data, 0);
    idle(); mem_ready = 1'b1; repeat (2) tick(); mem_ready = 1'b0;
`else
    st(84, 7); tick();
    memwrite = 1'b0; memread = 1'b1; dataadr = 84; #1;
    chk("t6_ldstall", stall, 1);
    tick();
    chk("t6_ldstall2", stall, 1);
    mem_ready = 1'b1; #1;
    chk("t6_ldstall3", stall, 1);
    tick();
    mem_ready = 1'b0;
    chk("t6_ldgo", stall, 0);
    chk("t6_empty", empty, 1);
    idle();
`endif

    // 1b. asynchronous reset during an active drain
    st(200, 1); tick();
    st(204, 2); tick();
    st(208, 3); tick();
    idle(); mem_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", mem_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_addr", mem_addr, 0);
    #12 reset = 1'b1;
    tick();
    mem_ready = 1'b0;

    // randomized traffic, with phases of slow and fast memory
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) prob = $urandom_range(10, 90);
      if ($urandom_range(0, 1) == 1) st($urandom_range(0, 31), $urandom);
      else begin
        memwrite  = 1'b0;
        memread   = ($urandom_range(0, 3) == 0);
        dataadr   = $urandom_range(0, 31);
      end
      mem_ready = ($urandom_range(0, 99) < prob);
      tick();
    end
    idle(); mem_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    chk("final_empty", empty, 1);
    run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
